alu_cmd_sequencer: RTL and testbench

Initiator side of the 4-bit ALU operand/opcode interface. Accepts ALU commands (A, B, opcode) over a valid/ready stream into a small FIFO. Issues each command to the external combinational ALU, captures result and carry, and returns them over a valid/ready response stream. Sits between the control/datapath front end and the ALU instance, and serialises all ALU use.

---
 rtl/alu_cmd_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
//   Initiator side of the 4-bit ALU operand/opcode interface. Commands
//   (A, B, opcode) arrive on a valid/ready stream into a small FIFO, are
//   issued one at a time to an external combinational ALU, and the captured
//   result/carry is returned on a valid/ready response stream.
//
//   Optional build macro: ALU_SEQ_ILLEGAL_OP_EN
//     defined   - opcodes 101/110/111 are flagged illegal: not issued to the
//                 ALU, answered with result 0, carry 0, rsp_err 1.
//     undefined - every opcode is issued; rsp_err stays 0.
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   cmd_valid/ready, cmd_a/b/op command stream in
//   alu_a/b/opcode             registered operands to the ALU
//   alu_result/carry           combinational ALU response
//   rsp_valid/ready, rsp_*     response stream out
//   busy                       FSM active or FIFO non-empty
//   fifo_level                 FIFO occupancy
//   done_cnt                   responses handed off (wraps)

module alu_cmd_sequencer #(
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_W      = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          cmd_valid,
   output logic                          cmd_ready,
   input  logic [3:0]                    cmd_a,
   input  logic [3:0]                    cmd_b,
   input  logic [2:0]                    cmd_op,
   output logic [3:0]                    alu_a,
   output logic [3:0]                    alu_b,
   output logic [2:0]                    alu_opcode,
   input  logic [3:0]                    alu_result,
   input  logic                          alu_carry,
   output logic                          rsp_valid,
   input  logic                          rsp_ready,
   output logic [3:0]                    rsp_result,
   output logic                          rsp_carry,
   output logic [2:0]                    rsp_op,
   output logic                          rsp_err,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic [CNT_W-1:0]              done_cnt
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t state_q, state_d;

   // ---------------------------------------------------------------
   // Command FIFO: entry = {op, b, a}
   // ---------------------------------------------------------------
   logic [10:0]      mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [LVL_W-1:0] count;
   logic             full, empty, push, pop;
   logic [10:0]      head;
   logic [3:0]       head_a, head_b;
   logic [2:0]       head_op;
   logic             ill_pop;

   assign full      = (count == LVL_W'(FIFO_DEPTH));
   assign empty     = (count == '0);
   assign cmd_ready = !full;
   assign push      = cmd_valid && !full;
   assign fifo_level = count;

   assign head    = mem[rd_ptr];
   assign head_a  = head[3:0];
   assign head_b  = head[7:4];
   assign head_op = head[10:8];

`ifdef ALU_SEQ_ILLEGAL_OP_EN
   // 101, 110, 111 are not ALU operations
   assign ill_pop = head_op[2] & (head_op[1] | head_op[0]);
`else
   assign ill_pop = 1'b0;
`endif

   // Storage needs no reset: entries are only read when count says valid.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {cmd_op, cmd_b, cmd_a};
   end

   // Power-of-two depth lets the pointers wrap by plain overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + LVL_W'(1);
            2'b01:   count <= count - LVL_W'(1);
            default: count <= count;
         endcase
      end
   end

   // ---------------------------------------------------------------
   // Sequencing FSM
   // ---------------------------------------------------------------
   logic capture, rsp_clr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      capture = 1'b0;
      rsp_clr = 1'b0;
      case (state_q)
         IDLE: begin
            if (!empty) begin
               pop     = 1'b1;
               state_d = EXEC;
            end
         end
         EXEC: begin
            // alu_* were loaded last edge; ALU output has settled by now
            capture = 1'b1;
            state_d = RESP;
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_clr = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy = (state_q != IDLE) || !empty;

   // ---------------------------------------------------------------
   // ALU issue and response capture
   // ---------------------------------------------------------------
   // exec_op/exec_err carry the popped opcode to the capture edge, since an
   // illegal opcode never reaches alu_opcode.
   logic [2:0] exec_op;
   logic       exec_err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_a      <= '0;
         alu_b      <= '0;
         alu_opcode <= '0;
         exec_op    <= '0;
         exec_err   <= 1'b0;
         rsp_valid  <= 1'b0;
         rsp_result <= '0;
         rsp_carry  <= 1'b0;
         rsp_op     <= '0;
         rsp_err    <= 1'b0;
         done_cnt   <= '0;
      end else begin
         if (pop) begin
            exec_op  <= head_op;
            exec_err <= ill_pop;
            if (!ill_pop) begin
               alu_a      <= head_a;
               alu_b      <= head_b;
               alu_opcode <= head_op;
            end
         end
         if (capture) begin
            rsp_valid  <= 1'b1;
            rsp_result <= exec_err ? 4'd0 : alu_result;
            rsp_carry  <= exec_err ? 1'b0 : alu_carry;
            rsp_op     <= exec_op;
            rsp_err    <= exec_err;
         end else if (rsp_clr) begin
            rsp_valid <= 1'b0;
            done_cnt  <= done_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer: directed cases plus random
// traffic scored against a queue-based reference of accepted commands.
module tb_alu_cmd_sequencer;

   localparam int DEPTH = 4;
   localparam int CNT_W = 4;   // narrow so done_cnt wraps during the run
   localparam int LW    = $clog2(DEPTH) + 1;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             cmd_valid, cmd_ready;
   logic [3:0]       cmd_a, cmd_b;
   logic [2:0]       cmd_op;
   logic [3:0]       alu_a, alu_b, alu_result;
   logic [2:0]       alu_opcode;
   logic             alu_carry;
   logic             rsp_valid, rsp_ready, rsp_carry, rsp_err;
   logic [3:0]       rsp_result;
   logic [2:0]       rsp_op;
   logic             busy;
   logic [LW-1:0]    fifo_level;
   logic [CNT_W-1:0] done_cnt;

   always #5 clk = ~clk;

   alu_cmd_sequencer #(.FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
      .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
      .alu_result(alu_result), .alu_carry(alu_carry),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_result(rsp_result), .rsp_carry(rsp_carry),
      .rsp_op(rsp_op), .rsp_err(rsp_err),
      .busy(busy), .fifo_level(fifo_level), .done_cnt(done_cnt)
   );

   // Behavioural 4-bit ALU: {carry, result}; sub carry = borrow.
   function automatic logic [4:0] alu_fn(input logic [3:0] a, input logic [3:0] b,
                                         input logic [2:0] op);
      case (op)
         3'd0:    return {1'b0, a} + {1'b0, b};
         3'd1:    return {1'b0, a} - {1'b0, b};
         3'd2:    return {1'b0, a & b};
         3'd3:    return {1'b0, a | b};
         3'd4:    return {1'b0, ~a};
         default: return 5'd0;
      endcase
   endfunction

   assign {alu_carry, alu_result} = alu_fn(alu_a, alu_b, alu_opcode);

   typedef struct {
      logic [3:0] res;
      logic       c;
      logic [2:0] op;
      logic       err;
   } exp_t;

   function automatic exp_t ref_rsp(input logic [3:0] a, input logic [3:0] b,
                                    input logic [2:0] op);
      exp_t e;
      logic [4:0] r;
      r     = alu_fn(a, b, op);
      e.res = r[3:0];
      e.c   = r[4];
      e.op  = op;
      e.err = 1'b0;
`ifdef ALU_SEQ_ILLEGAL_OP_EN
      if (op >= 3'd5) begin
         e.res = 4'd0;
         e.c   = 1'b0;
         e.err = 1'b1;
      end
`endif
      return e;
   endfunction

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Scoreboard: accepted commands in order; responses must match the head.
   exp_t q[$];
   int   n_done = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         q.delete();
         n_done = 0;
      end else begin
         chk("done_cnt", 32'(done_cnt), 32'(n_done % (1 << CNT_W)));
         if (rsp_valid) begin
            if (q.size() == 0) chk("rsp_spurious", 32'(rsp_valid), 32'd0);
            else begin
               chk("rsp_result", 32'(rsp_result), 32'(q[0].res));
               chk("rsp_carry",  32'(rsp_carry),  32'(q[0].c));
               chk("rsp_op",     32'(rsp_op),     32'(q[0].op));
               chk("rsp_err",    32'(rsp_err),    32'(q[0].err));
               if (rsp_ready) begin
                  void'(q.pop_front());
                  n_done++;
               end
            end
         end
         if (cmd_valid && cmd_ready) q.push_back(ref_rsp(cmd_a, cmd_b, cmd_op));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue one command from idle, check latency and the returned fields.
   task automatic send_chk(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op,
                           input logic [3:0] res, input logic c, input logic err);
      int lat;
      cmd_a = a; cmd_b = b; cmd_op = op; cmd_valid = 1'b1; rsp_ready = 1'b1;
      lat = 0;
      while (!cmd_ready && lat < 20) begin step(); lat++; end
      step();                     // accept edge
      cmd_valid = 1'b0;
      lat = 1;                    // edges counted from and including accept
      while (!rsp_valid && lat < 20) begin step(); lat++; end
      chk("latency", 32'(lat), 32'd3);
      chk("d_result", 32'(rsp_result), 32'(res));
      chk("d_carry",  32'(rsp_carry),  32'(c));
      chk("d_op",     32'(rsp_op),     32'(op));
      chk("d_err",    32'(rsp_err),    32'(err));
      step();                     // handshake edge
   endtask

   task automatic drain();
      int n;
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      n = 0;
      while ((busy || rsp_valid) && n < 200) begin step(); n++; end
      chk("drain_idle", 32'(busy || rsp_valid), 32'd0);
      chk("drain_q", 32'(q.size()), 32'd0);
   endtask

   initial begin
      int acc, n, d0;
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0; rsp_ready = 1'b0;
      repeat (3) step();
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_busy",      32'(busy), 32'd0);
      chk("rst_level",     32'(fifo_level), 32'd0);
      chk("rst_alu",       32'({alu_a, alu_b, alu_opcode}), 32'd0);
      chk("rst_rsp",       32'({rsp_result, rsp_carry, rsp_op, rsp_err}), 32'd0);
      rst_n = 1'b1;
      step();

      // directed arithmetic
      send_chk(4'd3, 4'd4, 3'b000, 4'b0111, 1'b0, 1'b0);
      chk("done_first", 32'(done_cnt), 32'd1);
      send_chk(4'd2, 4'd5, 3'b001, 4'b1101, 1'b1, 1'b0);
      send_chk(4'd9, 4'd3, 3'b100, 4'b0110, 1'b0, 1'b0);

`ifdef ALU_SEQ_ILLEGAL_OP_EN
      send_chk(4'd7, 4'd7, 3'b110, 4'd0, 1'b0, 1'b1);
      chk("ill_alu_op", 32'(alu_opcode), 32'b100);
`else
      send_chk(4'd7, 4'd7, 3'b110, 4'd0, 1'b0, 1'b0);
      chk("op110_issued", 32'(alu_opcode), 32'b110);
`endif

      // capacity with consumer stalled
      rsp_ready = 1'b0;
      cmd_valid = 1'b1;
      acc = 0;
      for (int i = 0; i < 10; i++) begin
         cmd_a = 4'($urandom); cmd_b = 4'($urandom); cmd_op = 3'($urandom);
         if (cmd_ready) acc++;
         step();
      end
      cmd_valid = 1'b0;
      chk("fill_accepted", 32'(acc), 32'd5);
      chk("fill_ready",    32'(cmd_ready), 32'd0);
      chk("fill_level",    32'(fifo_level), 32'd4);
      d0 = int'(done_cnt);
      rsp_ready = 1'b1;
      n = 0;
      while (!cmd_ready && n < 20) begin step(); n++; end
      chk("ready_after_pop", 32'((int'(done_cnt) - d0) & ((1 << CNT_W) - 1)), 32'd1);
      chk("level_after_pop", 32'(fifo_level), 32'd3);
      drain();

      // consumer toggling every cycle
      rsp_ready = 1'b0;
      for (int i = 0; i < 40; i++) begin
         cmd_valid = (i < 6);
         cmd_a = 4'($urandom); cmd_b = 4'($urandom); cmd_op = 3'($urandom);
         rsp_ready = ~rsp_ready;
         step();
      end
      drain();

      // random traffic
      for (int i = 0; i < 400; i++) begin
         cmd_valid = ($urandom_range(0, 1) == 1);
         cmd_a = 4'($urandom); cmd_b = 4'($urandom); cmd_op = 3'($urandom);
         rsp_ready = ($urandom_range(0, 9) < 6);
         step();
      end
      drain();

      // reset while in EXEC with two commands queued
      rsp_ready = 1'b0;
      cmd_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cmd_a = 4'($urandom); cmd_b = 4'($urandom); cmd_op = 3'($urandom);
         step();
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      step();                     // handshake of first command
      rsp_ready = 1'b0;
      step();                     // pop of second -> EXEC
      chk("pre_rst_level", 32'(fifo_level), 32'd2);
      chk("pre_rst_valid", 32'(rsp_valid), 32'd0);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_level", 32'(fifo_level), 32'd0);
      chk("mid_rst_busy",  32'(busy), 32'd0);
      chk("mid_rst_done",  32'(done_cnt), 32'd0);
      chk("mid_rst_alu",   32'({alu_a, alu_b, alu_opcode}), 32'd0);
      chk("mid_rst_rsp",   32'({rsp_valid, rsp_result, rsp_carry, rsp_op, rsp_err}), 32'd0);
      chk("mid_rst_ready", 32'(cmd_ready), 32'd1);
      step();
      rst_n = 1'b1;
      rsp_ready = 1'b1;
      acc = 0;
      for (int i = 0; i < 8; i++) begin
         if (rsp_valid) acc++;
         step();
      end
      chk("post_rst_rsp",   32'(acc), 32'd0);
      chk("post_rst_level", 32'(fifo_level), 32'd0);
      chk("post_rst_done",  32'(done_cnt), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
